// File: rtl/cmp_pkg.sv
// Shared opcodes, FSM states and counter width for the compare arbiter.
package cmp_pkg;

    localparam logic [1:0] OP_EQ   = 2'b00;
    localparam logic [1:0] OP_GT   = 2'b01;
    localparam logic [1:0] OP_LT   = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

    function automatic logic op_result(
        input logic [1:0] op,
        input logic       lt,
        input logic       eq,
        input logic       gt
    );
        logic r;
        r = 1'b0;
        case (op)
            OP_EQ:   r = eq;
            OP_LT:   r = lt;
            OP_GT:   r = gt;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_arbiter_if.sv
// Requester-side bundle of the compare arbiter: requests, operands, grants, responses.
interface cmp_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ*2-1:0] op_in;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic              rsp_result;
    logic              rsp_lt;
    logic              rsp_eq;
    logic              rsp_gt;

    modport master (
        output req, a_in, b_in, op_in,
        input  gnt, rsp_valid, rsp_id, rsp_result,
        input  rsp_lt, rsp_eq, rsp_gt
    );

    modport slave (
        input  req, a_in, b_in, op_in,
        output gnt, rsp_valid, rsp_id, rsp_result,
        output rsp_lt, rsp_eq, rsp_gt
    );

endinterface

// File: rtl/cmp_core.sv
// Combinational unsigned W-bit magnitude compare; exactly one flag is high.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_lt,
    output logic         o_eq,
    output logic         o_gt
);

    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter/sequencer for one shared comparator.
// Optional per-requester grant counters under CMP_ARB_STATS_EN.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef CMP_ARB_STATS_EN
    input  logic                     stat_clr,
    output logic [NREQ*STAT_W-1:0]   stat_cnt,
`endif
    cmp_arbiter_if.slave             bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_win;
    logic [IW-1:0]     w_win;
    logic              w_any;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [1:0]        r_op;
    logic [NREQ-1:0]   r_gnt;
    logic              r_valid;
    logic [IW-1:0]     r_id;
    logic              r_res;
    logic              r_lt;
    logic              r_eq;
    logic              r_gt;
    logic              w_lt;
    logic              w_eq;
    logic              w_gt;

    assign w_any = |bus.req;

    // Scan from the far end back toward rr_ptr so the nearest hit wins.
    always_comb begin : pick
        int idx;
        w_win = r_rr_ptr;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req[idx]) begin
                w_win = IW'(idx);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = EVAL;
            EVAL:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    cmp_core #(.W(W)) u_core (
        .i_a  (r_a),
        .i_b  (r_b),
        .o_lt (w_lt),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_gnt    <= '0;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_res    <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win <= w_win;
                        r_a   <= bus.a_in[w_win*W +: W];
                        r_b   <= bus.b_in[w_win*W +: W];
                        r_op  <= bus.op_in[w_win*2 +: 2];
                        r_gnt <= NREQ'(1) << w_win;
                    end
                end
                EVAL: begin
                    r_lt    <= w_lt;
                    r_eq    <= w_eq;
                    r_gt    <= w_gt;
                    r_res   <= op_result(r_op, w_lt, w_eq, w_gt);
                    r_id    <= r_win;
                    r_valid <= 1'b1;
                end
                RESP: begin
                    r_rr_ptr <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.rsp_valid  = r_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_res;
    assign bus.rsp_lt     = r_lt;
    assign bus.rsp_eq     = r_eq;
    assign bus.rsp_gt     = r_gt;

`ifdef CMP_ARB_STATS_EN
    logic [STAT_W-1:0] r_cnt [NREQ];

    // Counts bump on the same edge that raises gnt; a clear wins over it.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_state == IDLE && w_any && r_cnt[w_win] != '1) begin
            r_cnt[w_win] <= r_cnt[w_win] + 1'b1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign stat_cnt[g*STAT_W +: STAT_W] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: directed scenarios plus random traffic against a job-level model.
module tb_cmp_arbiter;
    import cmp_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmp_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

`ifdef CMP_ARB_STATS_EN
    logic                   stat_clr;
    logic [NREQ*STAT_W-1:0] stat_cnt;
`endif

    cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CMP_ARB_STATS_EN
        .stat_clr (stat_clr),
        .stat_cnt (stat_cnt),
`endif
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Job-level model: age of the job in flight (0 none, 1 granted, 2 answered)
    int m_age, m_ptr, m_win, m_a, m_b, m_op;
    int e_id, e_res, e_lt, e_eq, e_gt;
    int m_cnt [NREQ];
    int g_idx [$];
    int g_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int fld(input logic [NREQ*W-1:0] v, input int i);
        return int'(v[i*W +: W]);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_age = 0; m_ptr = 0; m_win = 0;
            e_id = 0; e_res = 0; e_lt = 0; e_eq = 0; e_gt = 0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else begin
            if (m_age == 0) begin
                if (bus.req != 0) begin
                    m_win = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        if (m_win < 0 && bus.req[(m_ptr + k) % NREQ])
                            m_win = (m_ptr + k) % NREQ;
                    end
                    m_a   = fld(bus.a_in, m_win);
                    m_b   = fld(bus.b_in, m_win);
                    m_op  = int'(bus.op_in[m_win*2 +: 2]);
                    m_age = 1;
                    if (m_cnt[m_win] < 255) m_cnt[m_win]++;
                end
            end else if (m_age == 1) begin
                e_lt = (m_a < m_b) ? 1 : 0;
                e_eq = (m_a == m_b) ? 1 : 0;
                e_gt = (m_a > m_b) ? 1 : 0;
                case (m_op)
                    0:       e_res = e_eq;
                    1:       e_res = e_gt;
                    2:       e_res = e_lt;
                    default: e_res = 0;
                endcase
                e_id  = m_win;
                m_age = 2;
            end else begin
                m_ptr = (m_win + 1) % NREQ;
                m_age = 0;
            end
`ifdef CMP_ARB_STATS_EN
            if (stat_clr) for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
`endif
        end
    endtask

    task automatic tick();
        int eg;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        eg = (m_age == 1) ? (1 << m_win) : 0;
        chk("gnt",   32'(bus.gnt), eg);
        chk("valid", 32'(bus.rsp_valid), (m_age == 2) ? 1 : 0);
        chk("id",    32'(bus.rsp_id), e_id);
        chk("res",   32'(bus.rsp_result), e_res);
        chk("lt",    32'(bus.rsp_lt), e_lt);
        chk("eq",    32'(bus.rsp_eq), e_eq);
        chk("gt",    32'(bus.rsp_gt), e_gt);
        chk("excl",  32'((bus.gnt != 0) && bus.rsp_valid), 0);
`ifdef CMP_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            chk("cnt", 32'(stat_cnt[i*STAT_W +: STAT_W]), m_cnt[i]);
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
                g_idx.push_back(i);
                g_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input int b, input int op);
        bus.a_in[i*W +: W]  = W'(a);
        bus.b_in[i*W +: W]  = W'(b);
        bus.op_in[i*2 +: 2] = 2'(op);
    endtask

    initial begin
        logic [31:0] rnd;
        int exp_op [4];
        exp_op[0] = 1; exp_op[1] = 0; exp_op[2] = 0; exp_op[3] = 0;

        bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.op_in = '0;
        rst = 1'b1;
`ifdef CMP_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        do_reset();
        chk("rst_gnt",   32'(bus.gnt), 0);
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_id",    32'(bus.rsp_id), 0);
        chk("rst_res",   32'(bus.rsp_result), 0);
        chk("rst_flags", 32'({bus.rsp_lt, bus.rsp_eq, bus.rsp_gt}), 0);

        // single job
        set_req(0, 5, 9, 2);
        bus.req = 4'b0001;
        tick();
        chk("single_gnt", 32'(bus.gnt), 1);
        bus.req = '0;
        tick();
        chk("single_vld", 32'(bus.rsp_valid), 1);
        chk("single_id",  32'(bus.rsp_id), 0);
        chk("single_res", 32'(bus.rsp_result), 1);
        chk("single_flg", 32'({bus.rsp_lt, bus.rsp_eq, bus.rsp_gt}), 3'b100);
        tick();

        // opcode sweep on requester 2
        for (int op = 0; op < 4; op++) begin
            set_req(2, 7, 7, op);
            bus.req = 4'b0100;
            tick();
            chk("sweep_gnt", 32'(bus.gnt), 4'b0100);
            bus.req = '0;
            tick();
            chk("sweep_res", 32'(bus.rsp_result), exp_op[op]);
            chk("sweep_eq",  32'(bus.rsp_eq), 1);
            chk("sweep_id",  32'(bus.rsp_id), 2);
            tick();
        end

        // operand hold on requester 1
        set_req(1, 3, 8, 1);
        bus.req = 4'b0010;
        tick();
        chk("hold_gnt", 32'(bus.gnt), 4'b0010);
        set_req(1, 12, 8, 1);
        bus.req = '0;
        tick();
        chk("hold_res", 32'(bus.rsp_result), 0);
        chk("hold_lt",  32'(bus.rsp_lt), 1);
        tick();

        // all four requesting continuously from reset
        do_reset();
        g_idx.delete();
        g_cyc.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, i, 3, i);
        bus.req = 4'b1111;
        repeat (14) tick();
        bus.req = '0;
        chk("rr_count", 32'(g_idx.size() >= 5), 1);
        if (g_idx.size() >= 5) begin
            for (int j = 0; j < 5; j++) begin
                chk("rr_order", 32'(g_idx[j]), j % 4);
                if (j > 0) chk("rr_gap", 32'(g_cyc[j] - g_cyc[j-1]), 3);
            end
        end
        repeat (3) tick();

        // reset during EVAL aborts the job
        set_req(2, 1, 2, 2);
        bus.req = 4'b0100;
        tick();
        chk("abort_gnt0", 32'(bus.gnt), 4'b0100);
        bus.req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_gnt",   32'(bus.gnt), 0);
        chk("abort_valid", 32'(bus.rsp_valid), 0);
        bus.req = 4'b1111;
        tick();
        chk("abort_next", 32'(bus.gnt), 4'b0001);
        bus.req = '0;
        tick();
        chk("abort_noold", 32'(bus.rsp_id), 0);
        tick();

`ifdef CMP_ARB_STATS_EN
        do_reset();
        set_req(1, 4, 4, 0);
        bus.req = 4'b0010;
        repeat (257 * 3) tick();
        chk("stat_sat", 32'(stat_cnt[1*STAT_W +: STAT_W]), 255);
        stat_clr = 1'b1;
        tick();
        chk("stat_clr_gnt", 32'(bus.gnt), 4'b0010);
        chk("stat_clr",     32'(stat_cnt[1*STAT_W +: STAT_W]), 0);
        stat_clr = 1'b0;
        bus.req = '0;
        repeat (3) tick();
`endif

        // random traffic
        do_reset();
        repeat (2000) begin
            rnd = $urandom;
            bus.req = rnd[NREQ-1:0];
            rnd = $urandom;
            bus.a_in = rnd[NREQ*W-1:0];
            rnd = $urandom;
            bus.b_in = rnd[NREQ*W-1:0];
            rnd = $urandom;
            bus.op_in = rnd[NREQ*2-1:0];
            rst = ($urandom_range(0, 99) == 0);
`ifdef CMP_ARB_STATS_EN
            stat_clr = ($urandom_range(0, 49) == 0);
`endif
            tick();
        end
        rst = 1'b0;
        bus.req = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
